// File: rtl/i2c_byte_master.sv
// i2c_byte_master
//   Byte-level I2C bus master. Turns a START / WRITE / READ / STOP command
//   stream into open-drain SCL/SDA waveforms and returns one response per
//   command (read data or the slave ACK bit). SCL is built from four
//   quarter-periods, each QUARTER_DIV clk cycles long.
//
//   Optional build macro: I2C_CLOCK_STRETCH_EN
//     When defined, a quarter that releases SCL does not start counting
//     until scl_in reads high (slave clock stretching). Without it scl_in
//     is ignored.
//
// Ports
//   clk, reset_n           clock, async active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd                    0=START 1=WRITE 2=READ 3=STOP
//   cmd_wdata              WRITE byte, MSB first
//   cmd_nack_out           READ: 1 = master NACKs this byte
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata              last READ byte (held until next READ)
//   rsp_nack               WRITE: slave ACK bit (1 = NACK)
//   rsp_err                WRITE/READ issued while the bus is not owned
//   busy                   bus owned (between START and STOP)
//   scl, sda_out           open-drain drives, 1 = released
//   sda_in, scl_in         resolved bus lines
module i2c_byte_master #(
  parameter int QUARTER_DIV = 75
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       busy,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in,
  input  logic       scl_in
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_BIT, S_ACK, S_STOP} state_t;

  localparam logic [1:0]  CMD_START = 2'd0;
  localparam logic [1:0]  CMD_WRITE = 2'd1;
  localparam logic [1:0]  CMD_READ  = 2'd2;
  localparam logic [15:0] CNT_LAST  = 16'(QUARTER_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  q_q, q_d;          // quarter within the current bit
  logic [15:0] cnt_q, cnt_d;      // quarter divider
  logic [2:0]  bit_q, bit_d;      // data bits left after the current one
  logic [6:0]  tx_q, tx_d;        // remaining WRITE bits (MSB next)
  logic [7:0]  rx_q, rx_d;
  logic        rd_q, rd_d;        // current byte is a READ
  logic        nko_q, nko_d;      // master ACK/NACK to send after a READ
  logic        ackb_q, ackb_d;    // sampled slave ACK bit
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        busy_q, busy_d;
  logic        rv_q, rv_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rnack_q, rnack_d;
  logic        rerr_q, rerr_d;

  logic run, stall, tick, accept;

  // Divider only runs while a bus phase is in progress
  assign run = (state_q != S_IDLE) && (state_q != S_HOLD);

`ifdef I2C_CLOCK_STRETCH_EN
  // A released SCL that is still low is being stretched by the slave:
  // hold the quarter at its first count until the line comes up.
  assign stall = scl_q && !scl_in && (cnt_q == '0);
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  assign tick      = run && !stall && (cnt_q == CNT_LAST);
  assign cmd_ready = !run;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    nko_d   = nko_q;
    ackb_d  = ackb_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    busy_d  = busy_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    rnack_d = rnack_q;
    rerr_d  = rerr_q;
    // Idle/hold states keep the counter at zero, so an accepted command
    // always starts its first quarter from a fresh count.
    if (!run || stall || tick) cnt_d = '0;
    else                       cnt_d = cnt_q + 16'd1;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          case (cmd)
            CMD_START: begin
              state_d = S_START;
              q_d     = 2'd0;
              sda_d   = 1'b1;               // SCL left as it is
            end
            CMD_WRITE, CMD_READ: begin
              if (state_q == S_IDLE) begin
                rv_d    = 1'b1;             // no bus activity, just flag it
                rerr_d  = 1'b1;
                rnack_d = 1'b0;
              end else begin
                state_d = S_BIT;
                q_d     = 2'd0;
                bit_d   = 3'd7;
                rd_d    = (cmd == CMD_READ);
                nko_d   = cmd_nack_out;
                tx_d    = (cmd == CMD_READ) ? 7'h7F : cmd_wdata[6:0];
                scl_d   = 1'b0;
                sda_d   = (cmd == CMD_READ) ? 1'b1 : cmd_wdata[7];
              end
            end
            default: begin                  // STOP
              if (state_q == S_IDLE) begin
                rv_d    = 1'b1;
                rerr_d  = 1'b0;
                rnack_d = 1'b0;
              end else begin
                state_d = S_STOP;
                q_d     = 2'd0;
                scl_d   = 1'b0;
                sda_d   = 1'b0;
              end
            end
          endcase
        end
      end

      S_START: if (tick) begin
        q_d = q_q + 2'd1;
        case (q_q)
          2'd0: scl_d = 1'b1;
          2'd1: sda_d = 1'b0;               // SDA falls with SCL high
          2'd2: scl_d = 1'b0;
          default: begin
            state_d = S_HOLD;
            busy_d  = 1'b1;
            rv_d    = 1'b1;
            rnack_d = 1'b0;
            rerr_d  = 1'b0;
          end
        endcase
      end

      S_BIT: if (tick) begin
        q_d = q_q + 2'd1;
        case (q_q)
          2'd0: scl_d = 1'b1;
          2'd1: rx_d  = {rx_q[6:0], sda_in};
          2'd2: scl_d = 1'b0;
          default: begin
            if (bit_q == 3'd0) begin
              state_d = S_ACK;
              sda_d   = rd_q ? nko_q : 1'b1;  // release for slave ACK
            end else begin
              bit_d = bit_q - 3'd1;
              sda_d = tx_q[6];
              tx_d  = {tx_q[5:0], 1'b1};
            end
          end
        endcase
      end

      S_ACK: if (tick) begin
        q_d = q_q + 2'd1;
        case (q_q)
          2'd0: scl_d  = 1'b1;
          2'd1: ackb_d = sda_in;
          2'd2: scl_d  = 1'b0;
          default: begin
            state_d = S_HOLD;
            rv_d    = 1'b1;
            rnack_d = rd_q ? 1'b0 : ackb_q;
            rerr_d  = 1'b0;
            if (rd_q) rdata_d = rx_q;
          end
        endcase
      end

      S_STOP: if (tick) begin
        q_d = q_q + 2'd1;
        case (q_q)
          2'd0: scl_d = 1'b1;
          2'd1: sda_d = 1'b1;               // SDA rises with SCL high
          2'd2: ;
          default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            rv_d    = 1'b1;
            rnack_d = 1'b0;
            rerr_d  = 1'b0;
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      nko_q   <= 1'b0;
      ackb_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rnack_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      nko_q   <= nko_d;
      ackb_q  <= ackb_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rnack_q <= rnack_d;
      rerr_q  <= rerr_d;
    end
  end

  assign scl       = scl_q;
  assign sda_out   = sda_q;
  assign busy      = busy_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = rnack_q;
  assign rsp_err   = rerr_q;

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C bus master that drives the front-display I2C bus. Its downstream consumer is the U3090MG front-display controller at slave address 0x38.
- It converts a command stream (START / WRITE / READ / STOP) from the system-controller side into open-drain SCL/SDA waveforms. It returns one response per command: read data or the ACK status.
- Single clock domain; SCL is generated by a quarter-period tick divider.

Parameters:
- QUARTER_DIV, 75, clk cycles per SCL quarter-period (75 at 30 MHz gives 100 kHz SCL); legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd  in  2  0=START, 1=WRITE, 2=READ, 3=STOP
- cmd_wdata  in  8  byte for WRITE, sent MSB first
- cmd_nack_out  in  1  for READ: 1 = master sends NACK (last byte), 0 = master sends ACK
- rsp_valid  out  1  one-cycle pulse when a command completes
- rsp_rdata  out  8  byte received by READ; holds its value until the next READ completes
- rsp_nack  out  1  WRITE: sampled slave ACK bit (1 = NACK); 0 for other commands
- rsp_err  out  1  WRITE/READ issued while bus not owned
- busy  out  1  bus owned (between START and STOP)
- scl  out  1  SCL drive; 1 = released
- sda_out  out  1  SDA drive; 1 = released (wired-AND with slave)
- sda_in  in  1  resolved SDA line
- scl_in  in  1  resolved SCL line (used only with I2C_CLOCK_STRETCH_EN)

Behaviour:
- Reset (async, immediate):
  - scl=1, sda_out=1
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_err=0, busy=0
  - State IDLE; divider cleared.
- Divider: a counter counts 0..QUARTER_DIV-1 and emits a tick on wrap. It runs only outside IDLE/HOLD and restarts from 0 when a command is accepted.
- Handshake:
  - A command is accepted on cmd_valid && cmd_ready; cmd_wdata and cmd_nack_out are captured in that cycle.
  - cmd_ready=1 only in IDLE and HOLD. It goes low in the cycle after acceptance.
  - cmd_ready returns high in the same cycle rsp_valid pulses.
- States: IDLE (bus free, SCL=1, SDA=1), HOLD (bus owned, SCL=0), START_Q, BIT_Q, ACK_Q, STOP_Q. Each _Q state steps q0..q3, advancing one quarter per tick.
- START_Q, from IDLE or HOLD (repeated start):
  - q0: sda=1, scl unchanged
  - q1: scl=1
  - q2: sda=0
  - q3: scl=0
  - Then HOLD, busy=1, rsp_valid pulse.
- Data bit (WRITE/READ, 8 bits MSB first):
  - q0: scl=0, sda=bit (READ drives 1)
  - q1, q2: scl=1
  - q3: scl=0
  - sda_in is sampled on the tick ending q1.
- ACK_Q, 9th bit:
  - WRITE: sda released; sampled value goes to rsp_nack.
  - READ: sda=cmd_nack_out.
  - Then HOLD, rsp_valid pulse, rsp_rdata updated on READ.
- STOP_Q:
  - q0: scl=0, sda=0
  - q1: scl=1
  - q2: sda=1
  - q3: hold
  - Then IDLE, busy=0, rsp_valid pulse.
- Latency from acceptance to rsp_valid:
  - START/STOP: 4*QUARTER_DIV+1 cycles
  - WRITE/READ: 36*QUARTER_DIV+1 cycles
- Boundary cases:
  - WRITE/READ in IDLE: no bus activity; rsp_valid and rsp_err=1 on the next cycle.
  - STOP in IDLE: no bus activity; rsp_valid on the next cycle, rsp_err=0.
  - START in HOLD: repeated start; busy stays 1.
  - cmd_valid while cmd_ready=0: ignored; it must be held until accepted.
- Reset mid-transfer forces scl=1 and sda_out=1 at once. No STOP is generated; the slave resynchronises on its next START.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- With the macro: in any quarter that releases scl, the divider holds at 0 until scl_in reads 1. The quarter lasts QUARTER_DIV cycles after release is observed, so latencies grow by the stretch time.
- Without the macro: scl_in is unused and timing is exactly as stated above.

Test Plan:
- QUARTER_DIV=4; START, then WRITE 0x70, against the slave model at 0x38 -> slave ACKs, so rsp_nack=0, rsp_err=0. WRITE rsp_valid arrives 145 cycles after acceptance. Each SCL period is 16 cycles.
- START, WRITE 0x72 (address 0x39) -> no ACK, so rsp_nack=1; then STOP -> busy=0, bus idle with scl=1, sda=1.
- START, WRITE 0x71, READ with cmd_nack_out=1 -> rsp_rdata=0xFF; master NACK drives sda high on the 9th clock; STOP completes.
- READ issued in IDLE -> rsp_valid one cycle later with rsp_err=1; scl and sda never toggle.
- START, WRITE 0x70, START again, then STOP -> repeated start with busy held at 1. Check SDA falls while SCL=1 twice and rises while SCL=1 once.
- Assert reset_n=0 in the middle of bit 4 of a WRITE -> same-cycle scl=1, sda_out=1, busy=0, cmd_ready=1. With I2C_CLOCK_STRETCH_EN, hold scl_in low for 20 cycles -> WRITE latency grows by 20 cycles.
